// File: rtl/cond_flag_unit_if.sv
// cond_flag_unit_if: instruction request / result bundle for cond_flag_unit.
//   master : issues instructions (in_valid, cond, bank_sel, alu_flags, flag_we,
//            *_req, blk_*), drives out_ready and rd_bank; observes results.
//   slave  : the condition/flag unit; drives in_ready, out_valid, cond_ex,
//            reg_wr, mem_wr, pc_src, illegal and rd_flags.
interface cond_flag_unit_if #(
    parameter int NUM_BANKS = 2,
    parameter int MAX_BLK   = 4
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int BLK_W  = $clog2(MAX_BLK + 1);

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        cond;
    logic [BANK_W-1:0] bank_sel;
    logic [3:0]        alu_flags;
    logic [1:0]        flag_we;
    logic              reg_wr_req;
    logic              mem_wr_req;
    logic              pc_src_req;
    logic              blk_start;
    logic [BLK_W-1:0]  blk_len;
    logic [3:0]        blk_cond;
    logic              out_valid;
    logic              out_ready;
    logic              cond_ex;
    logic              reg_wr;
    logic              mem_wr;
    logic              pc_src;
    logic              illegal;
    logic [BANK_W-1:0] rd_bank;
    logic [3:0]        rd_flags;

    modport master (
        output in_valid, cond, bank_sel, alu_flags, flag_we,
               reg_wr_req, mem_wr_req, pc_src_req,
               blk_start, blk_len, blk_cond, out_ready, rd_bank,
        input  in_ready, out_valid, cond_ex, reg_wr, mem_wr, pc_src,
               illegal, rd_flags
    );

    modport slave (
        input  in_valid, cond, bank_sel, alu_flags, flag_we,
               reg_wr_req, mem_wr_req, pc_src_req,
               blk_start, blk_len, blk_cond, out_ready, rd_bank,
        output in_ready, out_valid, cond_ex, reg_wr, mem_wr, pc_src,
               illegal, rd_flags
    );
endinterface

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: ARM-style condition evaluation with NUM_BANKS NZCV flag
// banks and predicated blocks of up to MAX_BLK instructions sharing one
// condition. One instruction is accepted per in_valid/in_ready handshake and
// its results appear in a registered output stage one cycle later.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : cond_flag_unit_if slave (request, result, flag readback)
module cond_flag_unit #(
    parameter int NUM_BANKS = 2,
    parameter int MAX_BLK   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    cond_flag_unit_if.slave bus
);
    localparam int BLK_W = $clog2(MAX_BLK + 1);
    localparam logic [BLK_W-1:0] MAX_LEN = BLK_W'(MAX_BLK);

    typedef enum logic [3:0] {
        C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
        C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
        C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
        C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
    } cond_e;

    logic [3:0]       flags_q [NUM_BANKS];
    logic [3:0]       flags_d [NUM_BANKS];
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [3:0]       blk_cond_q, blk_cond_d;
    logic             out_valid_q, out_valid_d;
    logic             cond_ex_q, cond_ex_d;
    logic             reg_wr_q, reg_wr_d;
    logic             mem_wr_q, mem_wr_d;
    logic             pc_src_q, pc_src_d;
    logic             illegal_q, illegal_d;

    logic       in_ready_c;
    logic       accept;
    logic       blk_active;
    logic       sel_ok;
    logic       blk_bad;
    logic       cond_true;
    logic [3:0] cur_flags;
    logic [3:0] rd_flags_c;
    cond_e      eff_cond;
    logic       n, z, c, v;

    always_comb begin
        in_ready_c = !out_valid_q || bus.out_ready;
        accept     = bus.in_valid && in_ready_c;
        blk_active = (blk_cnt_q != '0);
        // Inside a block the latched block condition overrides the cond field.
        eff_cond   = cond_e'(blk_active ? blk_cond_q : bus.cond);
        sel_ok     = 32'(bus.bank_sel) < NUM_BANKS;
        cur_flags  = sel_ok ? flags_q[bus.bank_sel] : 4'b0000;
        {n, z, c, v} = cur_flags;

        case (eff_cond)
            C_EQ:    cond_true = z;
            C_NE:    cond_true = !z;
            C_CS:    cond_true = c;
            C_CC:    cond_true = !c;
            C_MI:    cond_true = n;
            C_PL:    cond_true = !n;
            C_VS:    cond_true = v;
            C_VC:    cond_true = !v;
            C_HI:    cond_true = c && !z;
            C_LS:    cond_true = !(c && !z);
            C_GE:    cond_true = (n == v);
            C_LT:    cond_true = (n != v);
            C_GT:    cond_true = !z && (n == v);
            C_LE:    cond_true = !(!z && (n == v));
            C_AL:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase

        blk_bad = bus.blk_start &&
                  (blk_active || (bus.blk_len == '0) || (bus.blk_len > MAX_LEN));

        flags_d     = flags_q;
        blk_cnt_d   = blk_cnt_q;
        blk_cond_d  = blk_cond_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        cond_ex_d   = cond_ex_q;
        reg_wr_d    = reg_wr_q;
        mem_wr_d    = mem_wr_q;
        pc_src_d    = pc_src_q;
        illegal_d   = illegal_q;

        if (accept) begin
            out_valid_d = 1'b1;
            cond_ex_d   = cond_true;
            reg_wr_d    = bus.reg_wr_req && cond_true;
            mem_wr_d    = bus.mem_wr_req && cond_true;
            pc_src_d    = bus.pc_src_req && cond_true;
            illegal_d   = (eff_cond == C_NV) || blk_bad;

            if (cond_true && sel_ok) begin
                if (bus.flag_we[1]) flags_d[bus.bank_sel][3:2] = bus.alu_flags[3:2];
                if (bus.flag_we[0]) flags_d[bus.bank_sel][1:0] = bus.alu_flags[1:0];
            end

            if (blk_active) begin
                blk_cnt_d = blk_cnt_q - 1'b1;
            end else if (bus.blk_start && !blk_bad) begin
                blk_cnt_d  = bus.blk_len;
                blk_cond_d = bus.blk_cond;
            end
        end

        rd_flags_c = (32'(bus.rd_bank) < NUM_BANKS) ? flags_q[bus.rd_bank] : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q     <= '{default: 4'b0000};
            blk_cnt_q   <= '0;
            blk_cond_q  <= '0;
            out_valid_q <= 1'b0;
            cond_ex_q   <= 1'b0;
            reg_wr_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            pc_src_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            blk_cnt_q   <= blk_cnt_d;
            blk_cond_q  <= blk_cond_d;
            out_valid_q <= out_valid_d;
            cond_ex_q   <= cond_ex_d;
            reg_wr_q    <= reg_wr_d;
            mem_wr_q    <= mem_wr_d;
            pc_src_q    <= pc_src_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.cond_ex   = cond_ex_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.pc_src    = pc_src_q;
    assign bus.illegal   = illegal_q;
    assign bus.rd_flags  = rd_flags_c;
endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: directed scenarios plus a randomized run checked against
// a behavioural model of the condition/flag/block rules.
module tb_cond_flag_unit;
    localparam int NB = 2;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cond_flag_unit_if #(.NUM_BANKS(NB), .MAX_BLK(MB)) bus ();
    cond_flag_unit #(.NUM_BANKS(NB), .MAX_BLK(MB)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [3:0] m_flags [NB];
    int m_blk_cnt;
    int m_blk_cond;
    bit m_ov, m_cex, m_rw, m_mw, m_pc, m_ill;

    function automatic bit cond_holds(input int cc, input logic [3:0] f);
        bit fn, fz, fc, fv;
        fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
        case (cc)
            0:  return fz;
            1:  return !fz;
            2:  return fc;
            3:  return !fc;
            4:  return fn;
            5:  return !fn;
            6:  return fv;
            7:  return !fv;
            8:  return fc && !fz;
            9:  return !(fc && !fz);
            10: return fn == fv;
            11: return fn != fv;
            12: return !fz && (fn == fv);
            13: return !(!fz && (fn == fv));
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic step();
        logic [3:0] f;
        int eff;
        bit ex, bad;
        if (!reset_n) begin
            foreach (m_flags[i]) m_flags[i] = 4'b0000;
            m_blk_cnt = 0; m_blk_cond = 0;
            m_ov = 0; m_cex = 0; m_rw = 0; m_mw = 0; m_pc = 0; m_ill = 0;
        end else if (bus.in_valid && (!m_ov || bus.out_ready)) begin
            eff = (m_blk_cnt > 0) ? m_blk_cond : int'(bus.cond);
            f   = m_flags[bus.bank_sel];
            ex  = cond_holds(eff, f);
            bad = bus.blk_start && (m_blk_cnt > 0 || int'(bus.blk_len) == 0 || int'(bus.blk_len) > MB);
            m_ov = 1; m_cex = ex;
            m_rw = bus.reg_wr_req && ex;
            m_mw = bus.mem_wr_req && ex;
            m_pc = bus.pc_src_req && ex;
            m_ill = (eff == 15) || bad;
            if (ex) begin
                if (bus.flag_we[1]) f[3:2] = bus.alu_flags[3:2];
                if (bus.flag_we[0]) f[1:0] = bus.alu_flags[1:0];
                m_flags[bus.bank_sel] = f;
            end
            if (m_blk_cnt > 0) m_blk_cnt = m_blk_cnt - 1;
            else if (bus.blk_start && !bad) begin
                m_blk_cnt = int'(bus.blk_len);
                m_blk_cond = int'(bus.blk_cond);
            end
        end else if (bus.out_ready) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.cond = 4'hE; bus.bank_sel = '0; bus.alu_flags = '0;
        bus.flag_we = '0; bus.reg_wr_req = 0; bus.mem_wr_req = 0; bus.pc_src_req = 0;
        bus.blk_start = 0; bus.blk_len = '0; bus.blk_cond = '0; bus.out_ready = 1;
        bus.rd_bank = '0;
    endtask

    task automatic instr(input logic [3:0] c, input logic [0:0] b,
                         input logic [1:0] we, input logic [3:0] alu);
        idle();
        bus.in_valid = 1; bus.cond = c; bus.bank_sel = b; bus.flag_we = we; bus.alu_flags = alu;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        step(); step();
        reset_n = 1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if ({bus.cond_ex, bus.reg_wr, bus.mem_wr, bus.pc_src, bus.illegal} !== 5'b0)
            begin errors++; $display("FAIL rst_outputs got=%b exp=00000", {bus.cond_ex, bus.reg_wr, bus.mem_wr, bus.pc_src, bus.illegal}); end
        bus.rd_bank = 1; #1;
        checks++; if (bus.rd_flags !== 4'b0000) begin errors++; $display("FAIL rst_flags1 got=%b exp=0000", bus.rd_flags); end
    endtask

    task automatic test_eq_write();
        instr(4'h0, 1'b0, 2'b11, 4'b0100); step();
        checks++; if (bus.cond_ex !== 1'b0) begin errors++; $display("FAIL eq_first cond_ex got=%b exp=0", bus.cond_ex); end
        checks++; if (bus.rd_flags !== 4'b0000) begin errors++; $display("FAIL eq_nowrite rd_flags got=%b exp=0000", bus.rd_flags); end
        instr(4'hE, 1'b0, 2'b11, 4'b0100); step();
        checks++; if (bus.rd_flags !== 4'b0100) begin errors++; $display("FAIL al_write rd_flags got=%b exp=0100", bus.rd_flags); end
        instr(4'h0, 1'b0, 2'b00, 4'b0000); step();
        checks++; if (bus.cond_ex !== 1'b1) begin errors++; $display("FAIL eq_second cond_ex got=%b exp=1", bus.cond_ex); end
    endtask

    task automatic test_banks();
        instr(4'hE, 1'b1, 2'b11, 4'b1000); step();
        instr(4'hA, 1'b1, 2'b00, 4'b0000); step();
        checks++; if (bus.cond_ex !== 1'b0) begin errors++; $display("FAIL ge_bank1 cond_ex got=%b exp=0", bus.cond_ex); end
        instr(4'hB, 1'b1, 2'b00, 4'b0000); step();
        checks++; if (bus.cond_ex !== 1'b1) begin errors++; $display("FAIL lt_bank1 cond_ex got=%b exp=1", bus.cond_ex); end
        bus.rd_bank = 0; #1;
        checks++; if (bus.rd_flags !== 4'b0100) begin errors++; $display("FAIL bank0_kept got=%b exp=0100", bus.rd_flags); end
        bus.rd_bank = 1; #1;
        checks++; if (bus.rd_flags !== 4'b1000) begin errors++; $display("FAIL bank1_val got=%b exp=1000", bus.rd_flags); end
    endtask

    task automatic test_illegal();
        instr(4'hF, 1'b0, 2'b11, 4'b1111); bus.reg_wr_req = 1; step();
        checks++; if ({bus.cond_ex, bus.reg_wr, bus.illegal} !== 3'b001)
            begin errors++; $display("FAIL nv_cond got=%b exp=001", {bus.cond_ex, bus.reg_wr, bus.illegal}); end
        checks++; if (bus.rd_flags !== 4'b0100) begin errors++; $display("FAIL nv_nowrite got=%b exp=0100", bus.rd_flags); end
    endtask

    task automatic test_block();
        instr(4'hE, 1'b0, 2'b11, 4'b0000); step();
        instr(4'hE, 1'b0, 2'b00, 4'b0000);
        bus.blk_start = 1; bus.blk_len = 3'd3; bus.blk_cond = 4'h1; step();
        checks++; if ({bus.cond_ex, bus.illegal} !== 2'b10) begin errors++; $display("FAIL blk_open got=%b exp=10", {bus.cond_ex, bus.illegal}); end
        for (int i = 0; i < 3; i++) begin
            instr(4'h0, 1'b0, 2'b00, 4'b0000); step();
            checks++; if (bus.cond_ex !== 1'b1) begin errors++; $display("FAIL blk_member%0d cond_ex got=%b exp=1", i, bus.cond_ex); end
        end
        instr(4'h0, 1'b0, 2'b00, 4'b0000); step();
        checks++; if (bus.cond_ex !== 1'b0) begin errors++; $display("FAIL blk_after cond_ex got=%b exp=0", bus.cond_ex); end
        instr(4'hE, 1'b0, 2'b00, 4'b0000); bus.blk_start = 1; bus.blk_len = 3'd0; step();
        checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL blk_len0 illegal got=%b exp=1", bus.illegal); end
        instr(4'hE, 1'b0, 2'b00, 4'b0000); bus.blk_start = 1; bus.blk_len = 3'd5; step();
        checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL blk_len5 illegal got=%b exp=1", bus.illegal); end
        // neither bad start may have opened a block: EQ with Z=0 is false
        instr(4'h0, 1'b0, 2'b00, 4'b0000); step();
        checks++; if (bus.cond_ex !== 1'b0) begin errors++; $display("FAIL blk_bad_noload cond_ex got=%b exp=0", bus.cond_ex); end
        instr(4'hE, 1'b0, 2'b00, 4'b0000); bus.blk_start = 1; bus.blk_len = 3'd2; bus.blk_cond = 4'h1; step();
        instr(4'h0, 1'b0, 2'b00, 4'b0000); bus.blk_start = 1; bus.blk_len = 3'd2; bus.blk_cond = 4'h0; step();
        checks++; if ({bus.cond_ex, bus.illegal} !== 2'b11) begin errors++; $display("FAIL blk_nested got=%b exp=11", {bus.cond_ex, bus.illegal}); end
        instr(4'h0, 1'b0, 2'b00, 4'b0000); step();
        checks++; if (bus.cond_ex !== 1'b1) begin errors++; $display("FAIL blk_continue cond_ex got=%b exp=1", bus.cond_ex); end
        instr(4'h0, 1'b0, 2'b00, 4'b0000); step();
        checks++; if (bus.cond_ex !== 1'b0) begin errors++; $display("FAIL blk_closed cond_ex got=%b exp=0", bus.cond_ex); end
    endtask

    task automatic test_stall();
        idle(); step();
        instr(4'hE, 1'b0, 2'b11, 4'b1010); bus.reg_wr_req = 1; bus.out_ready = 0; step();
        instr(4'hE, 1'b0, 2'b11, 4'b0101); bus.mem_wr_req = 1; bus.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d got=%b exp=0", i, bus.in_ready); end
            step();
            checks++; if ({bus.out_valid, bus.cond_ex, bus.reg_wr, bus.mem_wr} !== 4'b1110)
                begin errors++; $display("FAIL stall_hold%0d got=%b exp=1110", i, {bus.out_valid, bus.cond_ex, bus.reg_wr, bus.mem_wr}); end
            checks++; if (bus.rd_flags !== 4'b1010) begin errors++; $display("FAIL stall_flags%0d got=%b exp=1010", i, bus.rd_flags); end
        end
        bus.out_ready = 1; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", bus.in_ready); end
        step();
        checks++; if ({bus.out_valid, bus.reg_wr, bus.mem_wr} !== 3'b101) begin errors++; $display("FAIL release_b got=%b exp=101", {bus.out_valid, bus.reg_wr, bus.mem_wr}); end
        checks++; if (bus.rd_flags !== 4'b0101) begin errors++; $display("FAIL release_flags got=%b exp=0101", bus.rd_flags); end
        instr(4'h0, 1'b0, 2'b00, 4'b0000); bus.pc_src_req = 1; step();
        checks++; if ({bus.out_valid, bus.cond_ex, bus.mem_wr, bus.pc_src} !== 4'b1101)
            begin errors++; $display("FAIL release_c got=%b exp=1101", {bus.out_valid, bus.cond_ex, bus.mem_wr, bus.pc_src}); end
        idle(); step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain out_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        instr(4'hE, 1'b0, 2'b11, 4'b0100); step();
        instr(4'hE, 1'b0, 2'b00, 4'b0000); bus.blk_start = 1; bus.blk_len = 3'd3; bus.blk_cond = 4'h0; step();
        instr(4'h5, 1'b0, 2'b00, 4'b0000); bus.out_ready = 0; step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre out_valid got=%b exp=1", bus.out_valid); end
        reset_n = 0; step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.rd_flags !== 4'b0000) begin errors++; $display("FAIL mid_rst flags0 got=%b exp=0000", bus.rd_flags); end
        reset_n = 1; idle(); bus.rd_bank = 1; #1;
        checks++; if ({bus.in_ready, bus.rd_flags} !== 5'b10000) begin errors++; $display("FAIL mid_rst ready_flags1 got=%b exp=10000", {bus.in_ready, bus.rd_flags}); end
        instr(4'h1, 1'b0, 2'b00, 4'b0000); step();
        checks++; if (bus.cond_ex !== 1'b1) begin errors++; $display("FAIL mid_rst blk_cleared cond_ex got=%b exp=1", bus.cond_ex); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 80) != 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.cond = 4'($urandom_range(0, 15));
            bus.bank_sel = 1'($urandom_range(0, 1));
            bus.alu_flags = 4'($urandom_range(0, 15));
            bus.flag_we = 2'($urandom_range(0, 3));
            bus.reg_wr_req = 1'($urandom_range(0, 1));
            bus.mem_wr_req = 1'($urandom_range(0, 1));
            bus.pc_src_req = 1'($urandom_range(0, 1));
            bus.blk_start = ($urandom_range(0, 4) == 0);
            bus.blk_len = 3'($urandom_range(0, 7));
            bus.blk_cond = 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.rd_bank = 1'($urandom_range(0, 1));
            #1;
            checks++; if (bus.in_ready !== (!m_ov || bus.out_ready))
                begin errors++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, bus.in_ready, (!m_ov || bus.out_ready)); end
            checks++; if (bus.rd_flags !== m_flags[bus.rd_bank])
                begin errors++; $display("FAIL rnd_rdflags[%0d] got=%b exp=%b", i, bus.rd_flags, m_flags[bus.rd_bank]); end
            step();
            checks++; if ({bus.out_valid, bus.cond_ex, bus.reg_wr, bus.mem_wr, bus.pc_src, bus.illegal} !==
                          {m_ov, m_cex, m_rw, m_mw, m_pc, m_ill})
                begin errors++; $display("FAIL rnd_out[%0d] got=%b exp=%b", i,
                    {bus.out_valid, bus.cond_ex, bus.reg_wr, bus.mem_wr, bus.pc_src, bus.illegal},
                    {m_ov, m_cex, m_rw, m_mw, m_pc, m_ill}); end
        end
        reset_n = 1;
        idle();
    endtask

    initial begin
        foreach (m_flags[i]) m_flags[i] = 4'b0000;
        m_blk_cnt = 0; m_blk_cond = 0;
        m_ov = 0; m_cex = 0; m_rw = 0; m_mw = 0; m_pc = 0; m_ill = 0;
        test_reset();
        test_eq_write();
        test_banks();
        test_illegal();
        test_block();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
